// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// decoded instruction classes and the datapath select codes.
package unidade_controle_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_ORI  = 4'h6;
   localparam logic [3:0] OP_LW   = 4'h7;
   localparam logic [3:0] OP_SW   = 4'h8;
   localparam logic [3:0] OP_BEQ  = 4'h9;
   localparam logic [3:0] OP_JAL  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_BUSCA,
      ST_DECODIFICA,
      ST_EXECUTA,
      ST_MEMORIA,
      ST_ESCRITA,
      ST_PARADO,
      ST_ERRO
   } estado_t;

   typedef enum logic [3:0] {
      CL_ULA,
      CL_IMM,
      CL_LW,
      CL_SW,
      CL_BEQ,
      CL_JAL,
      CL_NOP,
      CL_HALT,
      CL_ILEGAL
   } classe_t;

   localparam logic [2:0] ULA_ADD = 3'b000;
   localparam logic [2:0] ULA_SUB = 3'b001;
   localparam logic [2:0] ULA_AND = 3'b010;
   localparam logic [2:0] ULA_OR  = 3'b011;

   localparam logic [1:0] CTRL_ULA = 2'b00;
   localparam logic [1:0] CTRL_MD  = 2'b01;
   localparam logic [1:0] CTRL_PC  = 2'b10;

   localparam logic [1:0] PC_INC = 2'b00;
   localparam logic [1:0] PC_REL = 2'b01;
   localparam logic [1:0] PC_ABS = 2'b10;

endpackage

// File: rtl/unidade_controle_decodificador.sv
// Combinational opcode decoder: instruction class, ALU operation, extension
// mode and whether the ALU B operand comes from the extended constant.
module decodificador
   import unidade_controle_pkg::*;
(
   input  logic [3:0] opcode,
   output classe_t    classe,
   output logic [2:0] ula_op,
   output logic       sinal_ext,
   output logic       usa_imm
);

   always_comb begin
      classe    = CL_ILEGAL;
      ula_op    = ULA_ADD;
      sinal_ext = 1'b1;
      usa_imm   = 1'b0;
      case (opcode)
         OP_NOP:  classe = CL_NOP;
         OP_ADD:  classe = CL_ULA;
         OP_SUB:  begin classe = CL_ULA; ula_op = ULA_SUB; end
         OP_AND:  begin classe = CL_ULA; ula_op = ULA_AND; end
         OP_OR:   begin classe = CL_ULA; ula_op = ULA_OR;  end
         OP_ADDI: begin classe = CL_IMM; usa_imm = 1'b1; end
         OP_ORI:  begin
            classe    = CL_IMM;
            ula_op    = ULA_OR;
            usa_imm   = 1'b1;
            sinal_ext = 1'b0;
         end
         OP_LW:   begin classe = CL_LW; usa_imm = 1'b1; end
         OP_SW:   begin classe = CL_SW; usa_imm = 1'b1; end
         OP_BEQ:  begin classe = CL_BEQ; ula_op = ULA_SUB; end
         OP_JAL:  classe = CL_JAL;
         OP_HALT: classe = CL_HALT;
         default: classe = CL_ILEGAL;
      endcase
   end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetches over a req/ready memory port, latches the
// instruction and sequences every datapath select/enable per instruction class.
//
// state         | meaning
// ST_BUSCA      | fetch: mem_req until mem_pronto, then load IR and PC+1
// ST_DECODIFICA | classify IR; NOP/HALT retire here, B..E trap
// ST_EXECUTA    | ALU op/operand drive; BEQ and JAL finish here
// ST_MEMORIA    | data access at ALU address until mem_pronto
// ST_ESCRITA    | register bank write from ALU or memory data
// ST_PARADO     | HALT reached, absorbing
// ST_ERRO       | illegal opcode, absorbing
module unidade_controle
   import unidade_controle_pkg::*;
#(
   parameter int CONT_W = 16
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic [31:0]       instrucao,
   input  logic              mem_pronto,
   input  logic              ula_zero,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_sel_dado,
   output logic              pc_load,
   output logic [1:0]        pc_src,
   output logic [2:0]        ula_op,
   output logic              ula_src_b,
   output logic              BR_HabEscrita,
   output logic              EXcontrole,
   output logic [1:0]        controle,
   output logic [3:0]        Sel_C_A,
   output logic [3:0]        Sel_B,
   output logic [15:0]       constante,
   output logic              parado,
   output logic              erro,
   output logic [CONT_W-1:0] instr_cont
);

   estado_t     estado;
   logic [31:0] ir;
   classe_t     classe;
   logic [2:0]  dec_ula_op;
   logic        dec_sinal;
   logic        dec_imm;
   logic        busca_ok;
   logic        unused_ir_bits;

   decodificador u_dec (
      .opcode    (ir[31:28]),
      .classe    (classe),
      .ula_op    (dec_ula_op),
      .sinal_ext (dec_sinal),
      .usa_imm   (dec_imm)
   );

   assign Sel_C_A        = ir[27:24];
   assign Sel_B          = ir[23:20];
   assign constante      = ir[15:0];
   assign unused_ir_bits = ^ir[19:16];

   // A fetch completes only once the registered request is actually out.
   assign busca_ok = (estado == ST_BUSCA) && mem_req && mem_pronto;

   assign pc_load = busca_ok ||
                    ((estado == ST_EXECUTA) &&
                     (((classe == CL_BEQ) && ula_zero) || (classe == CL_JAL)));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado        <= ST_BUSCA;
         ir            <= '0;
         instr_cont    <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_sel_dado  <= 1'b0;
         pc_src        <= PC_INC;
         ula_op        <= ULA_ADD;
         ula_src_b     <= 1'b0;
         BR_HabEscrita <= 1'b0;
         EXcontrole    <= 1'b0;
         controle      <= CTRL_ULA;
         parado        <= 1'b0;
         erro          <= 1'b0;
      end else begin
         // Outputs are registered for the state being entered; single-state
         // strobes fall back to idle unless the transition sets them.
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_sel_dado  <= 1'b0;
         BR_HabEscrita <= 1'b0;
         controle      <= CTRL_ULA;
         pc_src        <= PC_INC;
         case (estado)
            ST_BUSCA: begin
               if (busca_ok) begin
                  ir     <= instrucao;
                  estado <= ST_DECODIFICA;
               end else begin
                  mem_req <= 1'b1;
               end
            end
            ST_DECODIFICA: begin
               case (classe)
                  CL_NOP: begin
                     estado     <= ST_BUSCA;
                     mem_req    <= 1'b1;
                     instr_cont <= instr_cont + CONT_W'(1);
                  end
                  CL_HALT: begin
                     estado     <= ST_PARADO;
                     parado     <= 1'b1;
                     instr_cont <= instr_cont + CONT_W'(1);
                  end
                  CL_ILEGAL: begin
                     estado <= ST_ERRO;
                     erro   <= 1'b1;
                  end
                  default: begin
                     estado     <= ST_EXECUTA;
                     ula_op     <= dec_ula_op;
                     ula_src_b  <= dec_imm;
                     EXcontrole <= dec_sinal;
                     if (classe == CL_BEQ) begin
                        pc_src <= PC_REL;
                     end
                     if (classe == CL_JAL) begin
                        pc_src        <= PC_ABS;
                        BR_HabEscrita <= 1'b1;
                        controle      <= CTRL_PC;
                     end
                  end
               endcase
            end
            ST_EXECUTA: begin
               case (classe)
                  CL_LW, CL_SW: begin
                     estado       <= ST_MEMORIA;
                     mem_req      <= 1'b1;
                     mem_sel_dado <= 1'b1;
                     mem_we       <= (classe == CL_SW);
                  end
                  CL_ULA, CL_IMM: begin
                     estado        <= ST_ESCRITA;
                     BR_HabEscrita <= 1'b1;
                  end
                  default: begin
                     estado     <= ST_BUSCA;
                     mem_req    <= 1'b1;
                     instr_cont <= instr_cont + CONT_W'(1);
                  end
               endcase
            end
            ST_MEMORIA: begin
               if (!mem_pronto) begin
                  mem_req      <= 1'b1;
                  mem_sel_dado <= 1'b1;
                  mem_we       <= (classe == CL_SW);
               end else if (classe == CL_SW) begin
                  estado     <= ST_BUSCA;
                  mem_req    <= 1'b1;
                  instr_cont <= instr_cont + CONT_W'(1);
               end else begin
                  // LW keeps the data access open so MD stays valid for the write.
                  estado        <= ST_ESCRITA;
                  mem_req       <= 1'b1;
                  mem_sel_dado  <= 1'b1;
                  BR_HabEscrita <= 1'b1;
                  controle      <= CTRL_MD;
               end
            end
            ST_ESCRITA: begin
               estado     <= ST_BUSCA;
               mem_req    <= 1'b1;
               instr_cont <= instr_cont + CONT_W'(1);
            end
            ST_PARADO, ST_ERRO: begin
               estado <= estado;
            end
            default: begin
               estado <= ST_ERRO;
               erro   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: per-cycle expected control vectors are
// queued as stimulus is driven and compared mid-cycle on the falling edge.
module tb_unidade_controle;

   localparam int CONT_W = 3;

   localparam logic [31:0] I_ADD  = 32'h13100000;
   localparam logic [31:0] I_LW   = 32'h75000004;
   localparam logic [31:0] I_SW   = 32'h82300010;
   localparam logic [31:0] I_BEQ  = 32'h91200008;
   localparam logic [31:0] I_JAL  = 32'hA7000040;
   localparam logic [31:0] I_ORI  = 32'h6450FFFF;
   localparam logic [31:0] I_NOP  = 32'h00000000;
   localparam logic [31:0] I_ILG  = 32'hC0000000;
   localparam logic [31:0] I_HALT = 32'hF0000000;

   logic              clock;
   logic              reset_n;
   logic [31:0]       instrucao;
   logic              mem_pronto;
   logic              ula_zero;
   logic              mem_req;
   logic              mem_we;
   logic              mem_sel_dado;
   logic              pc_load;
   logic [1:0]        pc_src;
   logic [2:0]        ula_op;
   logic              ula_src_b;
   logic              BR_HabEscrita;
   logic              EXcontrole;
   logic [1:0]        controle;
   logic [3:0]        Sel_C_A;
   logic [3:0]        Sel_B;
   logic [15:0]       constante;
   logic              parado;
   logic              erro;
   logic [CONT_W-1:0] instr_cont;

   logic [15:0] obs;
   logic [15:0] exp_q[$];
   logic [2:0]  s_op;
   logic        s_srcb;
   logic        s_ex;
   int          n_chk;
   int          n_ok;

   unidade_controle #(.CONT_W(CONT_W)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .instrucao     (instrucao),
      .mem_pronto    (mem_pronto),
      .ula_zero      (ula_zero),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_sel_dado  (mem_sel_dado),
      .pc_load       (pc_load),
      .pc_src        (pc_src),
      .ula_op        (ula_op),
      .ula_src_b     (ula_src_b),
      .BR_HabEscrita (BR_HabEscrita),
      .EXcontrole    (EXcontrole),
      .controle      (controle),
      .Sel_C_A       (Sel_C_A),
      .Sel_B         (Sel_B),
      .constante     (constante),
      .parado        (parado),
      .erro          (erro),
      .instr_cont    (instr_cont)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign obs = {mem_req, mem_we, mem_sel_dado, pc_load, pc_src, ula_op,
                 ula_src_b, BR_HabEscrita, EXcontrole, controle, parado, erro};

   // ula_op / ula_src_b / EXcontrole are sticky, so they come from s_*.
   function automatic logic [15:0] mk(input logic req, input logic we,
                                      input logic sel, input logic pcl,
                                      input logic [1:0] pcs, input logic br,
                                      input logic [1:0] ctl, input logic par,
                                      input logic err);
      return {req, we, sel, pcl, pcs, s_op, s_srcb, br, s_ex, ctl, par, err};
   endfunction

   function automatic logic [15:0] idle();
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
   endfunction

   function automatic logic [15:0] busca(input logic p);
      return mk(1'b1, 1'b0, 1'b0, p, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      assert (got === want) n_ok++;
      else $error("FAIL %s: observed %h expected %h", tag, got, want);
   endtask

   task automatic passo(input string tag, input logic p, input logic z,
                        input logic [31:0] ins, input logic [15:0] expv);
      logic [15:0] e;
      exp_q.push_back(expv);
      @(posedge clock);
      #1;
      mem_pronto = p;
      ula_zero   = z;
      instrucao  = ins;
      @(negedge clock);
      e = exp_q.pop_front();
      chk(tag, {16'h0, obs}, {16'h0, e});
   endtask

   task automatic sticky(input logic [2:0] op, input logic srcb, input logic ex);
      s_op   = op;
      s_srcb = srcb;
      s_ex   = ex;
   endtask

   initial begin
      n_chk = 0;
      n_ok  = 0;
      reset_n    = 1'b0;
      mem_pronto = 1'b0;
      ula_zero   = 1'b0;
      instrucao  = 32'h0;
      sticky(3'b000, 1'b0, 1'b0);
      repeat (2) @(negedge clock);
      chk("reset_out", {16'h0, obs}, 32'h0);
      chk("reset_cont", {29'h0, instr_cont}, 32'h0);
      chk("reset_ir", {8'h0, Sel_C_A, Sel_B, constante}, 32'h0);
      #2 reset_n = 1'b1;

      // ADD: write only in cycle 4
      passo("add_busca", 1, 0, I_ADD, busca(1));
      passo("add_decod", 1, 0, I_ADD, idle());
      chk("add_fields", {8'h0, Sel_C_A, Sel_B, constante}, {8'h0, 4'h3, 4'h1, 16'h0000});
      sticky(3'b000, 1'b0, 1'b1);
      passo("add_exec", 1, 0, I_ADD, idle());
      passo("add_escrita", 1, 0, I_ADD, mk(0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0));

      // LW with two wait cycles in MEMORIA, write in cycle 7
      passo("lw_busca", 1, 0, I_LW, busca(1));
      chk("cont_add", {29'h0, instr_cont}, 32'd1);
      passo("lw_decod", 0, 0, I_LW, idle());
      sticky(3'b000, 1'b1, 1'b1);
      passo("lw_exec", 1, 0, I_LW, idle());
      passo("lw_mem_w1", 0, 0, I_LW, mk(1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
      passo("lw_mem_w2", 0, 0, I_LW, mk(1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
      passo("lw_mem_ok", 1, 0, I_LW, mk(1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0));
      passo("lw_escrita", 1, 0, I_LW, mk(1, 0, 1, 0, 2'b00, 1, 2'b01, 0, 0));

      // SW with one wait cycle in BUSCA
      passo("sw_busca_w", 0, 0, I_SW, busca(0));
      chk("cont_lw", {29'h0, instr_cont}, 32'd2);
      passo("sw_busca", 1, 0, I_SW, busca(1));
      passo("sw_decod", 1, 0, I_SW, idle());
      passo("sw_exec", 1, 0, I_SW, idle());
      passo("sw_mem", 1, 0, I_SW, mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 0, 0));

      // BEQ taken, then not taken
      passo("beq1_busca", 1, 0, I_BEQ, busca(1));
      chk("cont_sw", {29'h0, instr_cont}, 32'd3);
      passo("beq1_decod", 1, 0, I_BEQ, idle());
      sticky(3'b001, 1'b0, 1'b1);
      passo("beq1_exec", 1, 1, I_BEQ, mk(0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 0));
      passo("beq0_busca", 1, 0, I_BEQ, busca(1));
      passo("beq0_decod", 1, 1, I_BEQ, idle());
      passo("beq0_exec", 1, 0, I_BEQ, mk(0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0));

      // JAL: link write and PC load in the same cycle
      passo("jal_busca", 1, 0, I_JAL, busca(1));
      chk("cont_beq", {29'h0, instr_cont}, 32'd5);
      passo("jal_decod", 1, 0, I_JAL, idle());
      sticky(3'b000, 1'b0, 1'b1);
      passo("jal_exec", 1, 0, I_JAL, mk(0, 0, 0, 1, 2'b10, 1, 2'b10, 0, 0));

      // ORI: zero extension
      passo("ori_busca", 1, 0, I_ORI, busca(1));
      chk("cont_jal", {29'h0, instr_cont}, 32'd6);
      passo("ori_decod", 1, 0, I_ORI, idle());
      chk("ori_fields", {8'h0, Sel_C_A, Sel_B, constante}, {8'h0, 4'h4, 4'h5, 16'hFFFF});
      sticky(3'b011, 1'b1, 1'b0);
      passo("ori_exec", 1, 0, I_ORI, idle());
      passo("ori_escrita", 1, 0, I_ORI, mk(0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0));

      // NOP retires in two cycles; counter wraps 7 -> 0
      passo("nop_busca", 1, 0, I_NOP, busca(1));
      chk("cont_ori", {29'h0, instr_cont}, 32'd7);
      passo("nop_decod", 1, 0, I_NOP, idle());

      // Illegal opcode traps and stays trapped
      passo("ilg_busca", 1, 0, I_ILG, busca(1));
      chk("cont_wrap", {29'h0, instr_cont}, 32'd0);
      passo("ilg_decod", 1, 0, I_ILG, idle());
      for (int i = 0; i < 3; i++) begin
         passo("ilg_erro", 1, 1, I_ILG, mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
      end
      chk("cont_ilg", {29'h0, instr_cont}, 32'd0);

      #2 reset_n = 1'b0;
      sticky(3'b000, 1'b0, 1'b0);
      #1 chk("rst_erro", {16'h0, obs}, 32'h0);
      @(negedge clock);
      #2 reset_n = 1'b1;

      // HALT
      passo("halt_busca", 1, 0, I_HALT, busca(1));
      passo("halt_decod", 1, 0, I_HALT, idle());
      passo("halt_p1", 1, 0, I_HALT, mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
      passo("halt_p2", 1, 0, I_ADD, mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
      chk("cont_halt", {29'h0, instr_cont}, 32'd1);

      #2 reset_n = 1'b0;
      sticky(3'b000, 1'b0, 1'b0);
      @(negedge clock);
      #2 reset_n = 1'b1;

      // Reset during SW memory access
      passo("swr_busca", 1, 0, I_SW, busca(1));
      passo("swr_decod", 1, 0, I_SW, idle());
      sticky(3'b000, 1'b1, 1'b1);
      passo("swr_exec", 1, 0, I_SW, idle());
      passo("swr_mem", 0, 0, I_SW, mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 0, 0));
      #1 reset_n = 1'b0;
      sticky(3'b000, 1'b0, 1'b0);
      #1 chk("rst_mem", {16'h0, obs}, 32'h0);
      @(negedge clock);
      chk("rst_mem_cont", {29'h0, instr_cont}, 32'd0);
      #2 reset_n = 1'b1;
      passo("pos_busca", 1, 0, I_NOP, busca(1));
      passo("pos_decod", 1, 0, I_NOP, idle());
      passo("pos_busca2", 0, 0, I_NOP, busca(0));
      chk("pos_cont", {29'h0, instr_cont}, 32'd1);

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
